// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
   localparam int         ENTRY_W          = 10;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO. The head entry is presented on rd_data whenever
// the FIFO is non-empty. A write into a full FIFO is accepted only when a pop
// happens in the same cycle and frees a slot.
module ps2_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   // Gated so the output reads zero while the FIFO is empty, including after reset.
   assign rd_data = empty ? '0 : mem[rptr];

   // Storage array; no reset needed since empty entries are never presented.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with clock glitch filter, full frame check,
// per-frame watchdog and a show-ahead receive FIFO.
// Optional build macro PS2_SCANCODE_DECODE_EN folds E0/F0 prefixes into
// bits 9:8 of the following entry instead of queuing them raw.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling edge with dat=0)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit and classifying the frame
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int TIMEOUT_US = 2000,
   parameter int FILTER_LEN = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        CLOCK_50,
   input  logic                        resetn,
   inout  wire                         PS2_CLK,
   inout  wire                         PS2_DAT,
   input  logic                        rd_en,
   output logic [ENTRY_W-1:0]          rd_data,
   output logic                        rd_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   input  logic                        clr_overflow,
   output logic                        parity_err,
   output logic                        frame_err
);

   localparam int TIMEOUT_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
   localparam int WD_W        = $clog2(TIMEOUT_CYC + 1);
   localparam int FL_W        = $clog2(FILTER_LEN);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [FL_W-1:0] FL_LAST = FL_W'(FILTER_LEN - 1);

   // The receiver never drives the bus.
   assign PS2_CLK = 1'bz;
   assign PS2_DAT = 1'bz;

   logic [1:0]         clk_sync;
   logic [1:0]         dat_sync;
   logic               filt_clk;
   logic [FL_W-1:0]    filt_cnt;
   logic               fall;
   logic               dat_s;

   ps2_state_t         state;
   ps2_state_t         state_nxt;
   logic [2:0]         bit_idx;
   logic [2:0]         bit_nxt;
   logic [7:0]         shreg;
   logic [7:0]         shreg_nxt;
   logic               par_bit;
   logic               par_nxt;
   logic               perr;
   logic               ferr;
   logic               good;

   logic [WD_W-1:0]    wd_cnt;
   logic               wd_expire;

   logic               push_req;
   logic [ENTRY_W-1:0] push_entry;
   logic               push_q;
   logic [ENTRY_W-1:0] push_data_q;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;

   // Two-flop synchronisers; reset to the idle (high) bus level.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DAT};
      end
   end

   assign dat_s = dat_sync[1];

   // Saturating filter: the filtered clock follows only after FILTER_LEN
   // consecutive samples disagreeing with it.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_sync[1] == filt_clk) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FL_LAST) begin
         filt_clk <= clk_sync[1];
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   // Edge is flagged on the same cycle the filtered clock is about to drop.
   assign fall = filt_clk && !clk_sync[1] && (filt_cnt == FL_LAST);

   // Watchdog down-counter: reloaded on every edge and while idle.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn)                    wd_cnt <= WD_LOAD;
      else if (state == IDLE || fall) wd_cnt <= WD_LOAD;
      else if (wd_cnt != '0)          wd_cnt <= wd_cnt - 1'b1;
   end

   assign wd_expire = (state != IDLE) && !fall && (wd_cnt == '0);

   // FSM and frame datapath registers.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         bit_idx <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_idx <= bit_nxt;
         shreg   <= shreg_nxt;
         par_bit <= par_nxt;
      end
   end

   // Next-state, shift and frame classification.
   always_comb begin
      state_nxt = state;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      par_nxt   = par_bit;
      perr      = 1'b0;
      ferr      = 1'b0;
      good      = 1'b0;
      if (wd_expire) begin
         state_nxt = IDLE;
         ferr      = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (!dat_s) begin
                  state_nxt = DATA;
                  bit_nxt   = 3'd0;
               end
            end
            DATA: begin
               shreg_nxt = {dat_s, shreg[7:1]};
               bit_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = PARITY;
            end
            PARITY: begin
               par_nxt   = dat_s;
               state_nxt = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (!odd_parity_ok(shreg, par_bit)) perr = 1'b1;
               else if (!dat_s)                    ferr = 1'b1;
               else                                good = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

`ifdef PS2_SCANCODE_DECODE_EN
   logic is_ext;
   logic is_brk;

   // Prefix tracking; any error or any non-prefix byte (pushed or dropped) clears it.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         is_ext <= 1'b0;
         is_brk <= 1'b0;
      end else if (perr || ferr) begin
         is_ext <= 1'b0;
         is_brk <= 1'b0;
      end else if (good) begin
         if (shreg == PS2_PREFIX_EXT) begin
            is_ext <= 1'b1;
         end else if (shreg == PS2_PREFIX_BREAK) begin
            is_brk <= 1'b1;
         end else begin
            is_ext <= 1'b0;
            is_brk <= 1'b0;
         end
      end
   end

   assign push_req   = good && (shreg != PS2_PREFIX_EXT) && (shreg != PS2_PREFIX_BREAK);
   assign push_entry = {is_brk, is_ext, shreg};
`else
   assign push_req   = good;
   assign push_entry = {2'b00, shreg};
`endif

   // Push request and error pulses are registered one cycle after the stop edge.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         push_q      <= 1'b0;
         push_data_q <= '0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         push_q      <= push_req;
         push_data_q <= push_entry;
         parity_err  <= perr;
         frame_err   <= ferr;
      end
   end

   assign pop      = rd_en && rd_valid;
   assign rd_valid = !fifo_empty;

   // Sticky overflow; a new drop wins over a simultaneous clear.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn)                          overflow <= 1'b0;
      else if (push_q && fifo_full && !pop) overflow <= 1'b1;
      else if (clr_overflow)                overflow <= 1'b0;
   end

   ps2_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (CLOCK_50),
      .rst_n   (resetn),
      .wr_en   (push_q),
      .wr_data (push_data_q),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo. Watchdog is scaled to 100 system cycles and
// the PS/2 bit period to 40 system cycles to keep the run short.
module tb_ps2_rx_fifo;

   localparam int HALF = 20;

   logic       clk_sys = 1'b0;
   logic       resetn;
   logic       clk_drv;
   logic       dat_drv;
   wire        ps2_clk;
   wire        ps2_dat;
   logic       rd_en;
   logic [9:0] rd_data;
   logic       rd_valid;
   logic [3:0] fifo_count;
   logic       overflow;
   logic       clr_overflow;
   logic       parity_err;
   logic       frame_err;

   int checks = 0;
   int errors = 0;
   int perr_cnt = 0;
   int ferr_cnt = 0;

   assign ps2_clk = clk_drv;
   assign ps2_dat = dat_drv;

   always #5 clk_sys = ~clk_sys;

   ps2_rx_fifo #(
      .CLK_HZ     (1000000),
      .TIMEOUT_US (100),
      .FILTER_LEN (8),
      .FIFO_DEPTH (8)
   ) dut (
      .CLOCK_50     (clk_sys),
      .resetn       (resetn),
      .PS2_CLK      (ps2_clk),
      .PS2_DAT      (ps2_dat),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .parity_err   (parity_err),
      .frame_err    (frame_err)
   );

   always @(negedge clk_sys) begin
      if (parity_err) perr_cnt++;
      if (frame_err)  ferr_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   // One bit: data set mid-high, falling edge, low phase, rising edge.
   // Glitch mode adds a 3-cycle low pulse in the high phase and a 3-cycle
   // high pulse in the low phase.
   task automatic send_bit(input logic b, input logic glitch);
      dat_drv = b;
      if (glitch) begin
         wait_cyc(4); clk_drv = 1'b0; wait_cyc(3); clk_drv = 1'b1; wait_cyc(3);
      end else begin
         wait_cyc(HALF / 2);
      end
      clk_drv = 1'b0;
      if (glitch) begin
         wait_cyc(12); clk_drv = 1'b1; wait_cyc(3); clk_drv = 1'b0; wait_cyc(5);
      end else begin
         wait_cyc(HALF);
      end
      clk_drv = 1'b1;
      wait_cyc(HALF / 2);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                             input logic glitch);
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
      send_bit(~(^d) ^ par_flip, glitch);
      send_bit(stop, glitch);
      dat_drv = 1'b1;
      wait_cyc(40);
   endtask

   task automatic pop_check(input string tag, input logic [9:0] exp);
      check_val({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
      check_val({tag, "_data"}, {22'd0, rd_data}, {22'd0, exp});
      rd_en = 1'b1;
      wait_cyc(1);
      rd_en = 1'b0;
   endtask

   initial begin
      #5ms;
      $display("FAIL global_timeout reached got stuck expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      int f0;
      resetn       = 1'b0;
      clk_drv      = 1'b1;
      dat_drv      = 1'b1;
      rd_en        = 1'b0;
      clr_overflow = 1'b0;
      wait_cyc(5);
      check_val("rst_valid", {31'd0, rd_valid}, 32'd0);
      check_val("rst_count", {28'd0, fifo_count}, 32'd0);
      check_val("rst_data", {22'd0, rd_data}, 32'd0);
      check_val("rst_ovf", {31'd0, overflow}, 32'd0);
      check_val("rst_errs", {30'd0, parity_err, frame_err}, 32'd0);
      resetn = 1'b1;
      wait_cyc(20);

      // Good frame 0x1C.
      p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      check_val("good_count", {28'd0, fifo_count}, 32'd1);
      check_val("good_errs", perr_cnt - p0 + ferr_cnt - f0, 32'd0);
      pop_check("good_1c", 10'h01C);
      check_val("good_count_after_pop", {28'd0, fifo_count}, 32'd0);
      check_val("good_valid_after_pop", {31'd0, rd_valid}, 32'd0);

      // Bad parity, then good 0x2D.
      p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      check_val("par_pulse", perr_cnt - p0, 32'd1);
      check_val("par_no_ferr", ferr_cnt - f0, 32'd0);
      check_val("par_count", {28'd0, fifo_count}, 32'd0);
      send_frame(8'h2D, 1'b0, 1'b1, 1'b0);
      pop_check("par_next_2d", 10'h02D);

      // Bad stop bit.
      p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      check_val("stop_ferr", ferr_cnt - f0, 32'd1);
      check_val("stop_no_perr", perr_cnt - p0, 32'd0);
      check_val("stop_count", {28'd0, fifo_count}, 32'd0);

      // Overflow: nine frames into eight entries.
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
      check_val("ovf_count", {28'd0, fifo_count}, 32'd8);
      check_val("ovf_flag", {31'd0, overflow}, 32'd1);
      for (int i = 1; i <= 8; i++) begin
         check_val("ovf_drain_count", {28'd0, fifo_count}, 32'(9 - i));
         pop_check("ovf_drain", 10'(i));
      end
      check_val("ovf_empty", {31'd0, rd_valid}, 32'd0);
      check_val("ovf_sticky", {31'd0, overflow}, 32'd1);
      clr_overflow = 1'b1;
      wait_cyc(1);
      clr_overflow = 1'b0;
      check_val("ovf_cleared", {31'd0, overflow}, 32'd0);

      // Watchdog: start plus four bits, then silence.
      p0 = perr_cnt; f0 = ferr_cnt;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      dat_drv = 1'b1;
      wait_cyc(150);
      check_val("wd_ferr", ferr_cnt - f0, 32'd1);
      check_val("wd_no_perr", perr_cnt - p0, 32'd0);
      check_val("wd_count", {28'd0, fifo_count}, 32'd0);

      // Glitchy good frame 0x75.
      p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'h75, 1'b0, 1'b1, 1'b1);
      check_val("glitch_count", {28'd0, fifo_count}, 32'd1);
      check_val("glitch_errs", perr_cnt - p0 + ferr_cnt - f0, 32'd0);
      pop_check("glitch_75", 10'h075);

      // Prefix bytes.
      send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h75, 1'b0, 1'b1, 1'b0);
`ifdef PS2_SCANCODE_DECODE_EN
      check_val("dec_count", {28'd0, fifo_count}, 32'd1);
      pop_check("dec_375", 10'h375);
`else
      check_val("raw_count", {28'd0, fifo_count}, 32'd3);
      pop_check("raw_e0", 10'h0E0);
      pop_check("raw_f0", 10'h0F0);
      pop_check("raw_75", 10'h075);
`endif

      // Reset mid-frame with two entries queued.
      send_frame(8'h11, 1'b0, 1'b1, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      check_val("mid_pre_count", {28'd0, fifo_count}, 32'd2);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
      resetn = 1'b0;
      wait_cyc(3);
      check_val("mid_rst_count", {28'd0, fifo_count}, 32'd0);
      check_val("mid_rst_outs", {18'd0, rd_data, rd_valid, overflow, parity_err, frame_err},
                32'd0);
      dat_drv = 1'b1;
      wait_cyc(3);
      resetn = 1'b1;
      wait_cyc(20);
      p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      check_val("mid_post_count", {28'd0, fifo_count}, 32'd1);
      check_val("mid_post_errs", perr_cnt - p0 + ferr_cnt - f0, 32'd0);
      pop_check("mid_post_1c", 10'h01C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
